// File: rtl/conv_requant_drain_pkg.sv
// Shared types and defaults for the conv requantize/drain block.
package conv_pkg;

  localparam int ACC_W  = 27;
  localparam int OUT_W  = 8;
  localparam int NUM_PE = 4;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FLUSH
  } state_t;

endpackage

// File: rtl/conv_requant_drain_if.sv
// Valid/ready output stream carrying one requantized element and its PE index.
interface conv_requant_drain_if #(
  parameter int OUT_W = 8,
  parameter int IDX_W = 2
) ();

  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;
  logic [IDX_W-1:0]        out_idx;

  modport master (
    output out_valid,
    output out_data,
    output out_idx,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_idx,
    output out_ready
  );

endinterface

// File: rtl/conv_requant_drain_requant_unit.sv
// Combinational requantizer: bias add, round-half-up shift, optional ReLU, saturate.
module requant_unit #(
  parameter int ACC_W = 27,
  parameter int OUT_W = 8
) (
  input  logic signed [ACC_W-1:0] i_sum,
  input  logic signed [ACC_W-1:0] i_bias,
  input  logic [3:0]              i_shift,
  input  logic                    i_relu,
  output logic signed [OUT_W-1:0] o_data
);

  localparam int W = ACC_W + 2;
  localparam logic signed [W-1:0] MAXV = W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [W-1:0] MINV = ~MAXV;

  logic signed [W-1:0] w_t;
  logic signed [W-1:0] w_rnd;
  logic signed [W-1:0] w_r;
  logic signed [W-1:0] w_s;

  always_comb begin
    w_t   = W'(i_sum) + W'(i_bias);
    w_rnd = '0;
    if (i_shift != 4'd0)
      w_rnd = W'(1) << (i_shift - 4'd1);
    w_r = (w_t + w_rnd) >>> i_shift;
    if (i_relu && w_r < 0)
      w_r = '0;
    w_s = w_r;
    if (w_r > MAXV)
      w_s = MAXV;
    else if (w_r < MINV)
      w_s = MINV;
    o_data = w_s[OUT_W-1:0];
  end

endmodule

// File: rtl/conv_requant_drain.sv
// Latches all PE accumulators on capture and streams them out requantized, one per handshake.
module conv_requant_drain #(
  parameter  int NUM_PE = conv_pkg::NUM_PE,
  parameter  int ACC_W  = conv_pkg::ACC_W,
  parameter  int OUT_W  = conv_pkg::OUT_W,
  localparam int IDX_W  = $clog2(NUM_PE)
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    capture,
  input  logic [NUM_PE*ACC_W-1:0] sum_flat,
  input  logic signed [ACC_W-1:0] bias,
  input  logic [3:0]              shift,
  input  logic                    relu_en,
  output logic                    busy,
  output logic                    done,
  output logic                    cap_err,
  conv_requant_drain_if.master    out
);

  import conv_pkg::*;

  state_t r_state;
  state_t w_next;

  logic signed [ACC_W-1:0] r_buf [NUM_PE];
  logic signed [ACC_W-1:0] r_bias;
  logic [3:0]              r_shift;
  logic                    r_relu;
  logic [IDX_W-1:0]        r_idx;

  logic                    r_valid;
  logic signed [OUT_W-1:0] r_data;
  logic [IDX_W-1:0]        r_oidx;
  logic                    r_done;
  logic                    r_cap_err;

  logic                    w_load;
  logic                    w_hs;
  logic                    w_last;
  logic                    w_cap_ok;
  logic                    w_cap_bad;
  logic                    w_drain_ld;
  logic                    w_flush_clr;
  logic signed [OUT_W-1:0] w_rq;

  assign w_load = !r_valid || out.out_ready;
  assign w_hs   = r_valid && out.out_ready;
  assign w_last = r_idx == IDX_W'(NUM_PE - 1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (capture) w_next = DRAIN;
      DRAIN:   if (w_load && w_last) w_next = FLUSH;
      FLUSH:   if (w_hs) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_cap_ok    = 1'b0;
    w_cap_bad   = 1'b0;
    w_drain_ld  = 1'b0;
    w_flush_clr = 1'b0;
    unique case (1'b1)
      (r_state == IDLE): w_cap_ok = capture;
      (r_state == DRAIN): begin
        w_cap_bad  = capture;
        w_drain_ld = w_load;
      end
      (r_state == FLUSH): begin
        w_cap_bad   = capture;
        w_flush_clr = w_hs;
      end
      default: ;
    endcase
  end

  assign busy = r_state != IDLE;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_PE; i++)
        r_buf[i] <= '0;
      r_bias  <= '0;
      r_shift <= '0;
      r_relu  <= 1'b0;
    end else if (w_cap_ok) begin
      for (int i = 0; i < NUM_PE; i++)
        r_buf[i] <= sum_flat[i*ACC_W +: ACC_W];
      r_bias  <= bias;
      r_shift <= shift;
      r_relu  <= relu_en;
    end
  end

  // idx wraps to 0 on the last load so it never points past the buffer
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      r_idx <= '0;
    else if (w_cap_ok)
      r_idx <= '0;
    else if (w_drain_ld)
      r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
  end

  requant_unit #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) u_rq (
    .i_sum   (r_buf[r_idx]),
    .i_bias  (r_bias),
    .i_shift (r_shift),
    .i_relu  (r_relu),
    .o_data  (w_rq)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_oidx    <= '0;
      r_done    <= 1'b0;
      r_cap_err <= 1'b0;
    end else begin
      r_done    <= w_flush_clr;
      r_cap_err <= w_cap_bad;
      if (w_drain_ld) begin
        r_valid <= 1'b1;
        r_data  <= w_rq;
        r_oidx  <= r_idx;
      end else if (w_flush_clr) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out.out_valid = r_valid;
  assign out.out_data  = r_data;
  assign out.out_idx   = r_oidx;
  assign done          = r_done;
  assign cap_err       = r_cap_err;

endmodule

// File: tb/tb_conv_requant_drain.sv
// Directed-vector bench for conv_requant_drain at NUM_PE=4, ACC_W=27, OUT_W=8.
module tb_conv_requant_drain;

  localparam int NPE = 4;
  localparam int AW  = 27;
  localparam int OW  = 8;
  localparam int IW  = 2;

  logic                 clk      = 1'b0;
  logic                 resetn   = 1'b0;
  logic                 capture  = 1'b0;
  logic                 relu_en  = 1'b0;
  logic [NPE*AW-1:0]    sum_flat = '0;
  logic signed [AW-1:0] bias     = '0;
  logic [3:0]           shift    = '0;
  logic                 busy;
  logic                 done;
  logic                 cap_err;

  int errors = 0;
  int checks = 0;
  int got_d[$];
  int got_i[$];
  bit saw_done;

  conv_requant_drain_if #(.OUT_W(OW), .IDX_W(IW)) bus ();

  conv_requant_drain #(
    .NUM_PE (NPE),
    .ACC_W  (AW),
    .OUT_W  (OW)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .capture  (capture),
    .sum_flat (sum_flat),
    .bias     (bias),
    .shift    (shift),
    .relu_en  (relu_en),
    .busy     (busy),
    .done     (done),
    .cap_err  (cap_err),
    .out      (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [NPE*AW-1:0] pack4(input int s0, s1, s2, s3);
    return {AW'(s3), AW'(s2), AW'(s1), AW'(s0)};
  endfunction

  // called at a negedge; returns at the negedge right after the capture edge
  task automatic do_capture(input int s0, s1, s2, s3,
                            input int b, input int sh, input bit r);
    sum_flat = pack4(s0, s1, s2, s3);
    bias     = AW'(b);
    shift    = 4'(sh);
    relu_en  = r;
    capture  = 1'b1;
    @(negedge clk);
    capture  = 1'b0;
  endtask

  // collects elements with out_ready held high until done or budget expiry
  task automatic run_drain(input int budget);
    got_d.delete();
    got_i.delete();
    saw_done = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (done) begin
        saw_done = 1'b1;
        break;
      end
      if (bus.out_valid) begin
        got_d.push_back(int'(bus.out_data));
        got_i.push_back(int'(bus.out_idx));
      end
    end
  endtask

  task automatic test_reset();
    resetn        = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'sd0 || bus.out_idx !== 2'd0 ||
        busy !== 1'b0 || done !== 1'b0 || cap_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: v=%b d=%0d i=%0d busy=%b done=%b cerr=%b exp all 0",
               bus.out_valid, bus.out_data, bus.out_idx, busy, done, cap_err);
    end
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || cap_err !== 1'b0 || busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: done=%b cerr=%b busy=%b v=%b exp 0 0 0 0",
               done, cap_err, busy, bus.out_valid);
    end
  endtask

  task automatic test_basic();
    int exp_d[4];
    exp_d = '{25, -75, 127, 1};
    do_capture(100, -300, 1000, 5, 0, 2, 1'b0);
    checks++;
    if (busy !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_e0: busy=%b v=%b exp 1 0", busy, bus.out_valid);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || int'(bus.out_idx) !== k ||
          int'(bus.out_data) !== exp_d[k]) begin
        errors++;
        $display("FAIL basic_elem%0d: v=%b i=%0d d=%0d exp v=1 i=%0d d=%0d",
                 k, bus.out_valid, bus.out_idx, bus.out_data, k, exp_d[k]);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: done=%b v=%b busy=%b exp 1 0 0",
               done, bus.out_valid, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse: done=%b exp 0", done);
    end
  endtask

  task automatic test_relu();
    int exp_d[4];
    exp_d = '{25, 0, 127, 1};
    do_capture(100, -300, 1000, 5, 0, 2, 1'b1);
    run_drain(20);
    checks++;
    if (got_d.size() != 4 || !saw_done) begin
      errors++;
      $display("FAIL relu_count: got=%0d done=%b exp 4 1", got_d.size(), saw_done);
    end
    for (int k = 0; k < got_d.size() && k < 4; k++) begin
      checks++;
      if (got_d[k] !== exp_d[k] || got_i[k] !== k) begin
        errors++;
        $display("FAIL relu_elem%0d: d=%0d i=%0d exp d=%0d i=%0d",
                 k, got_d[k], got_i[k], exp_d[k], k);
      end
    end
  endtask

  task automatic test_arith();
    int sv[3][4];
    int bv[3];
    int shv[3];
    int ev[3][4];
    sv  = '{'{130, 137, -118, 0}, '{-200, 127, 128, -129},
            '{49152, -16384, 16383, -16385}};
    bv  = '{-10, 0, 0};
    shv = '{0, 0, 15};
    ev  = '{'{120, 127, -128, -10}, '{-128, 127, 127, -128}, '{2, 0, 0, -1}};
    for (int v = 0; v < 3; v++) begin
      do_capture(sv[v][0], sv[v][1], sv[v][2], sv[v][3], bv[v], shv[v], 1'b0);
      run_drain(20);
      checks++;
      if (got_d.size() != 4 || !saw_done) begin
        errors++;
        $display("FAIL arith%0d_count: got=%0d done=%b exp 4 1", v, got_d.size(), saw_done);
      end
      for (int k = 0; k < got_d.size() && k < 4; k++) begin
        checks++;
        if (got_d[k] !== ev[v][k] || got_i[k] !== k) begin
          errors++;
          $display("FAIL arith%0d_elem%0d: d=%0d i=%0d exp d=%0d i=%0d",
                   v, k, got_d[k], got_i[k], ev[v][k], k);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int pat[4];
    int exp_d[4];
    bit prev_v;
    bit prev_r;
    int prev_d;
    int prev_i;
    pat    = '{1, 0, 0, 1};
    exp_d  = '{25, -75, 127, 1};
    prev_v = 1'b0;
    prev_r = 1'b1;
    prev_d = 0;
    prev_i = 0;
    got_d.delete();
    got_i.delete();
    saw_done = 1'b0;
    do_capture(100, -300, 1000, 5, 0, 2, 1'b0);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) begin
        saw_done = 1'b1;
        break;
      end
      if (prev_v && !prev_r) begin
        checks++;
        if (bus.out_valid !== 1'b1 || int'(bus.out_data) !== prev_d ||
            int'(bus.out_idx) !== prev_i) begin
          errors++;
          $display("FAIL bp_hold_c%0d: v=%b d=%0d i=%0d exp v=1 d=%0d i=%0d",
                   c, bus.out_valid, bus.out_data, bus.out_idx, prev_d, prev_i);
        end
      end
      bus.out_ready = pat[c % 4][0];
      if (bus.out_valid && bus.out_ready) begin
        got_d.push_back(int'(bus.out_data));
        got_i.push_back(int'(bus.out_idx));
      end
      prev_v = bus.out_valid;
      prev_r = bus.out_ready;
      prev_d = int'(bus.out_data);
      prev_i = int'(bus.out_idx);
    end
    bus.out_ready = 1'b1;
    checks++;
    if (got_d.size() != 4 || !saw_done) begin
      errors++;
      $display("FAIL bp_count: got=%0d done=%b exp 4 1", got_d.size(), saw_done);
    end
    for (int k = 0; k < got_d.size() && k < 4; k++) begin
      checks++;
      if (got_d[k] !== exp_d[k] || got_i[k] !== k) begin
        errors++;
        $display("FAIL bp_elem%0d: d=%0d i=%0d exp d=%0d i=%0d",
                 k, got_d[k], got_i[k], exp_d[k], k);
      end
    end
  endtask

  task automatic test_cap_err();
    int exp_d[4];
    bool_t_dummy: begin end
    exp_d = '{25, -75, 127, 1};
    got_d.delete();
    got_i.delete();
    saw_done = 1'b0;
    do_capture(100, -300, 1000, 5, 0, 2, 1'b0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 2) begin
        checks++;
        if (cap_err !== 1'b1) begin
          errors++;
          $display("FAIL caperr_pulse: cerr=%b exp 1", cap_err);
        end
        capture = 1'b0;
      end
      if (c == 3) begin
        checks++;
        if (cap_err !== 1'b0) begin
          errors++;
          $display("FAIL caperr_width: cerr=%b exp 0", cap_err);
        end
      end
      if (done) begin
        saw_done = 1'b1;
        break;
      end
      if (c == 1) begin
        sum_flat = pack4(-50, 60, -70, 80);
        bias     = AW'(7);
        shift    = 4'd0;
        capture  = 1'b1;
      end
      if (bus.out_valid) begin
        got_d.push_back(int'(bus.out_data));
        got_i.push_back(int'(bus.out_idx));
      end
    end
    capture = 1'b0;
    checks++;
    if (got_d.size() != 4 || !saw_done) begin
      errors++;
      $display("FAIL caperr_count: got=%0d done=%b exp 4 1", got_d.size(), saw_done);
    end
    for (int k = 0; k < got_d.size() && k < 4; k++) begin
      checks++;
      if (got_d[k] !== exp_d[k] || got_i[k] !== k) begin
        errors++;
        $display("FAIL caperr_elem%0d: d=%0d i=%0d exp d=%0d i=%0d",
                 k, got_d[k], got_i[k], exp_d[k], k);
      end
    end
  endtask

  task automatic test_flush_capture();
    bit hit;
    hit = 1'b0;
    do_capture(5, 6, 7, 8, 0, 0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_idx == 2'd3) begin
        hit      = 1'b1;
        sum_flat = pack4(1, 1, 1, 1);
        capture  = 1'b1;
        break;
      end
    end
    @(negedge clk);
    capture = 1'b0;
    checks++;
    if (!hit || done !== 1'b1 || cap_err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_cap: hit=%b done=%b cerr=%b busy=%b exp 1 1 1 0",
               hit, done, cap_err, busy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_cap_idle: v=%b busy=%b exp 0 0", bus.out_valid, busy);
    end
  endtask

  task automatic test_reset_mid();
    int exp_d[4];
    exp_d = '{5, -5, 1, 0};
    do_capture(100, -300, 1000, 5, 0, 2, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_idx !== 2'd2) begin
      errors++;
      $display("FAIL rst_mid_pre: v=%b i=%0d exp 1 2", bus.out_valid, bus.out_idx);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'sd0 || bus.out_idx !== 2'd0 ||
        busy !== 1'b0 || done !== 1'b0 || cap_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_async: v=%b d=%0d i=%0d busy=%b done=%b cerr=%b exp all 0",
               bus.out_valid, bus.out_data, bus.out_idx, busy, done, cap_err);
    end
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_quiet: v=%b busy=%b exp 0 0", bus.out_valid, busy);
    end
    do_capture(40, -40, 4, -4, 0, 3, 1'b0);
    run_drain(20);
    checks++;
    if (got_d.size() != 4 || !saw_done) begin
      errors++;
      $display("FAIL rst_fresh_count: got=%0d done=%b exp 4 1", got_d.size(), saw_done);
    end
    for (int k = 0; k < got_d.size() && k < 4; k++) begin
      checks++;
      if (got_d[k] !== exp_d[k] || got_i[k] !== k) begin
        errors++;
        $display("FAIL rst_fresh_elem%0d: d=%0d i=%0d exp d=%0d i=%0d",
                 k, got_d[k], got_i[k], exp_d[k], k);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_relu();
    test_arith();
    test_backpressure();
    test_cap_err();
    test_flush_capture();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_requant_drain.md
CONV_REQUANT_DRAIN -- requirements
Module: conv_requant_drain

Interface
REQ-001 Parameter NUM_PE, 4, number of PE accumulators drained per capture (2..16).
REQ-002 Parameter ACC_W, 27, signed accumulator width per PE.
REQ-003 Parameter OUT_W, 8, signed output activation width.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 resetn  input  1  reset, asynchronous, active-low.
REQ-006 capture  input  1  one-cycle request to latch all PE sums.
REQ-007 sum_flat  input  NUM_PE*ACC_W  signed PE sums; element i at bits [i*ACC_W +: ACC_W].
REQ-008 bias  input  ACC_W  signed bias added to every element; sampled with capture.
REQ-009 shift  input  4  right-shift amount 0..15; sampled with capture.
REQ-010 relu_en  input  1  clamp negatives to 0; sampled with capture.
REQ-011 out_ready  input  1  downstream ready.
REQ-012 out_valid  output  1  out_data/out_idx hold a valid element.
REQ-013 out_data  output  OUT_W  requantized signed element.
REQ-014 out_idx  output  clog2(NUM_PE)  PE index of out_data.
REQ-015 busy  output  1  high whenever state is not IDLE.
REQ-016 done  output  1  one-cycle pulse after last element handshakes.
REQ-017 cap_err  output  1  one-cycle pulse when capture arrives while busy.

Function
REQ-018 FSM states: IDLE, DRAIN, FLUSH.
REQ-019 IDLE: capture=1 latches sum_flat, bias, shift, relu_en into internal buffer, clears idx to 0, moves to DRAIN.
REQ-020 Capture in DRAIN or FLUSH is ignored (buffer unchanged) and pulses cap_err next cycle.
REQ-021 Output register loads when (!out_valid || out_ready); handshake = out_valid && out_ready.
REQ-022 DRAIN: on each load, element idx is written to out_data, out_idx=idx, out_valid=1, idx increments.
REQ-023 Load of idx=NUM_PE-1 moves DRAIN to FLUSH.
REQ-024 FLUSH: handshake of last element clears out_valid, pulses done, returns to IDLE.
REQ-025 In DRAIN, handshake without a new load is impossible; with out_ready held 1, one element per cycle.
REQ-026 Latency: capture sampled at edge E0 -> out_valid=1, out_idx=0 after edge E1; last element valid after E(NUM_PE).
REQ-027 Backpressure: out_valid=1 and out_ready=0 holds out_data/out_idx stable; idx does not advance.
REQ-028 Arithmetic: t = sum + bias in ACC_W+1 bits, no overflow.
REQ-029 shift=0: r = t; shift=s>0: r = (t + 2^(s-1)) >>> s, arithmetic, in ACC_W+2 bits (round half up).
REQ-030 relu_en=1 and r<0: r = 0.
REQ-031 Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1] = [-128, 127] at default.
REQ-032 capture in same cycle as final FLUSH handshake: ignored with cap_err (state not IDLE that cycle).
REQ-033 done and cap_err never assert in the same cycle as reset release.

Reset
REQ-034 resetn=0 asynchronously forces state IDLE, idx 0, out_valid 0, out_data 0, out_idx 0, busy 0, done 0, cap_err 0, buffer 0.
REQ-035 Reset mid-drain aborts the drain; no further out_valid until a new capture after reset release.

Structure
REQ-036 Package conv_pkg holds ACC_W, OUT_W, default NUM_PE and the state enum (IDLE, DRAIN, FLUSH).
REQ-037 One combinational sub-module requant_unit (bias add, round-shift, ReLU, saturate), single instance fed by buffer[idx].
REQ-038 Buffer is NUM_PE x ACC_W registers; no memories.

Verification (NUM_PE=4, defaults)
REQ-039 sums {100,-300,1000,5}, bias 0, shift 2, relu 0, ready=1 -> out {25,-75,127,1}, idx 0..3 on consecutive cycles, done after idx 3.
REQ-040 Same sums, relu 1 -> out {25,0,127,1}.
REQ-041 sum 130, bias -10, shift 0 -> out 120; sum -200, bias 0, shift 0 -> -128.
REQ-042 ready toggled 1,0,0,1,... -> data stable while ready=0, no element lost or duplicated, order 0..3.
REQ-043 capture at cycle 2 of drain with different sums -> cap_err pulse, outputs still from first capture.
REQ-044 resetn low after idx 1 handshake -> all outputs 0 immediately; new capture produces full fresh sequence from idx 0.
